datapath_rf: RTL and testbench

//  Parametrised successor of the 4-bit two-register datapath. An accumulator X
//  and an NREGS-deep register file feed an 8-function ALU. Registered C/N/V

---
 rtl/datapath_rf.sv | 111 +++++++++++
 tb/tb_datapath_rf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/datapath_rf.sv
// Accumulator X plus NREGS-deep register file feeding an 8-function ALU with registered C/N/V flags; build option DATAPATH_ADC_EN makes op 7 add-with-carry.
// Latency: one cycle from enable to visible x/y/flags; y and zero are combinational reads.
// Backpressure: none; the controller drives enables every cycle and every register accepts them unconditionally.
module datapath_rf #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] imm,
    input  logic [2:0]       op_sel,
    input  logic             en_x,
    input  logic             en_flag,
    input  logic             en_rf,
    input  logic             rf_sel,
    input  logic [AW-1:0]    rd_addr,
    input  logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] f;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic             c_new;
    logic             v_new;
`ifdef DATAPATH_ADC_EN
    logic [WIDTH:0]   adc_ext;
`endif

    // No read bypass: a same-cycle write becomes visible on y only after the edge.
    assign y    = rf[rd_addr];
    assign zero = (x == '0);

    // ALU: result f plus the C/V values an arithmetic op would load; other ops keep the old flags.
    always_comb begin
        sum_ext = {1'b0, x} + {1'b0, y};
        dif_ext = {1'b0, x} - {1'b0, y};
`ifdef DATAPATH_ADC_EN
        adc_ext = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, carry};
`endif
        f     = x;
        c_new = carry;
        v_new = ovf;
        case (op_sel)
            3'd0: f = x;
            3'd1: f = ~x;
            3'd2: begin
                f     = sum_ext[MSB:0];
                c_new = sum_ext[WIDTH];
                v_new = (x[MSB] == y[MSB]) && (sum_ext[MSB] != x[MSB]);
            end
            3'd3: f = y;
            3'd4: begin
                // Top bit of the extended difference is the unsigned borrow (x < y).
                f     = dif_ext[MSB:0];
                c_new = dif_ext[WIDTH];
                v_new = (x[MSB] != y[MSB]) && (dif_ext[MSB] != x[MSB]);
            end
            3'd5: f = x & y;
            3'd6: f = x | y;
            3'd7: begin
`ifdef DATAPATH_ADC_EN
                f     = adc_ext[MSB:0];
                c_new = adc_ext[WIDTH];
                v_new = (x[MSB] == y[MSB]) && (adc_ext[MSB] != x[MSB]);
`else
                f     = x ^ y;
`endif
            end
            default: f = x;
        endcase
    end

    // Accumulator and status flags; flags move only together with an X load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x     <= '0;
            carry <= 1'b0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
        end else if (en_x) begin
            x <= f;
            if (en_flag) begin
                neg   <= f[MSB];
                carry <= c_new;
                ovf   <= v_new;
            end
        end
    end

    // Register file write port; written data uses pre-edge x and y just like X does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (en_rf) begin
            rf[wr_addr] <= rf_sel ? imm : f;
        end
    end

endmodule

// File: tb/tb_datapath_rf.sv
module tb_datapath_rf;

    localparam int WIDTH = 4;
    localparam int NREGS = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] imm;
    logic [2:0]       op_sel;
    logic             en_x, en_flag, en_rf, rf_sel;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic [WIDTH-1:0] x, y;
    logic             zero, carry, neg, ovf;

    always #5 clk = ~clk;

    datapath_rf #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset), .imm(imm), .op_sel(op_sel),
        .en_x(en_x), .en_flag(en_flag), .en_rf(en_rf), .rf_sel(rf_sel),
        .rd_addr(rd_addr), .wr_addr(wr_addr),
        .x(x), .y(y), .zero(zero), .carry(carry), .neg(neg), .ovf(ovf)
    );

    typedef struct {
        logic [2:0]       op;
        logic             ex, ef, er, rs;
        logic [WIDTH-1:0] im;
        logic [AW-1:0]    rd, wr;
        logic [WIDTH-1:0] xx, yy;
        logic             z, c, n, v;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] xx, yy;
        logic             z, c, n, v;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic [2:0] op, logic ex, logic ef, logic er, logic rs,
                                logic [WIDTH-1:0] im, logic [AW-1:0] rd, logic [AW-1:0] wr,
                                logic [WIDTH-1:0] xx, logic [WIDTH-1:0] yy,
                                logic z, logic c, logic n, logic v);
        vec_t r;
        r.op = op; r.ex = ex; r.ef = ef; r.er = er; r.rs = rs; r.im = im;
        r.rd = rd; r.wr = wr; r.xx = xx; r.yy = yy; r.z = z; r.c = c; r.n = n; r.v = v;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        op_sel = 3'd0; en_x = 1'b0; en_flag = 1'b0; en_rf = 1'b0; rf_sel = 1'b0;
        imm = '0; rd_addr = '0; wr_addr = '0;
    endtask

    // Drive one vector, queue its expectation, pop and compare after the edge.
    task automatic step(vec_t v, int idx);
        exp_t e, got;
        @(negedge clk);
        op_sel = v.op; en_x = v.ex; en_flag = v.ef; en_rf = v.er; rf_sel = v.rs;
        imm = v.im; rd_addr = v.rd; wr_addr = v.wr;
        e.xx = v.xx; e.yy = v.yy; e.z = v.z; e.c = v.c; e.n = v.n; e.v = v.v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("v%0d_x", idx), 32'(x), 32'(got.xx));
        chk($sformatf("v%0d_y", idx), 32'(y), 32'(got.yy));
        chk($sformatf("v%0d_zero", idx), 32'(zero), 32'(got.z));
        chk($sformatf("v%0d_carry", idx), 32'(carry), 32'(got.c));
        chk($sformatf("v%0d_neg", idx), 32'(neg), 32'(got.n));
        chk($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(got.v));
    endtask

    task automatic check_cleared(string tag);
        chk({tag, "_x"}, 32'(x), 32'h0);
        chk({tag, "_zero"}, 32'(zero), 32'h1);
        chk({tag, "_carry"}, 32'(carry), 32'h0);
        chk({tag, "_neg"}, 32'(neg), 32'h0);
        chk({tag, "_ovf"}, 32'(ovf), 32'h0);
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = AW'(a);
            #1;
            chk($sformatf("%s_rf%0d", tag, a), 32'(y), 32'h0);
        end
    endtask

    initial begin
        //            op ex ef er rs imm  rd wr   x     y    z  c  n  v
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h9, 1, 1, 4'h0, 4'h9, 1, 0, 0, 0)); // rf[1]<=9
        tbl.push_back(mk(3, 1, 0, 0, 0, 4'h0, 1, 0, 4'h9, 4'h9, 0, 0, 0, 0)); // x<=y
        tbl.push_back(mk(2, 1, 1, 0, 0, 4'h0, 1, 0, 4'h2, 4'h9, 0, 1, 0, 1)); // 9+9
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h3, 2, 3, 4'h2, 4'h0, 0, 1, 0, 1)); // rf[3]<=3
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h5, 3, 2, 4'h2, 4'h3, 0, 1, 0, 1)); // rf[2]<=5
        tbl.push_back(mk(3, 1, 0, 0, 0, 4'h0, 3, 0, 4'h3, 4'h3, 0, 1, 0, 1)); // x<=3
        tbl.push_back(mk(4, 1, 1, 0, 0, 4'h0, 2, 0, 4'hE, 4'h5, 0, 1, 1, 0)); // 3-5 borrow
        tbl.push_back(mk(2, 0, 1, 0, 0, 4'h0, 2, 0, 4'hE, 4'h5, 0, 1, 1, 0)); // en_flag w/o en_x
        tbl.push_back(mk(5, 1, 1, 0, 0, 4'h0, 2, 0, 4'h4, 4'h5, 0, 1, 0, 0)); // E&5, C holds
        tbl.push_back(mk(6, 1, 1, 0, 0, 4'h0, 1, 0, 4'hD, 4'h9, 0, 1, 1, 0)); // 4|9
        tbl.push_back(mk(1, 1, 1, 0, 0, 4'h0, 1, 0, 4'h2, 4'h9, 0, 1, 0, 0)); // ~D
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'h0, 0, 0, 4'h2, 4'h2, 0, 1, 0, 0)); // rf[0]<=f=x
        tbl.push_back(mk(2, 1, 1, 0, 0, 4'h0, 0, 0, 4'h4, 4'h2, 0, 0, 0, 0)); // 2+2
        tbl.push_back(mk(4, 1, 1, 0, 0, 4'h0, 1, 0, 4'hB, 4'h9, 0, 1, 1, 1)); // 4-9 ovf
        tbl.push_back(mk(4, 1, 1, 0, 0, 4'h0, 0, 0, 4'h9, 4'h2, 0, 0, 1, 0)); // B-2
        tbl.push_back(mk(2, 1, 1, 1, 0, 4'h0, 0, 3, 4'hB, 4'h2, 0, 0, 1, 0)); // x and rf[3] <= 9+2
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 3, 0, 4'hB, 4'hB, 0, 0, 1, 0)); // read rf[3]
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'hF, 2, 2, 4'hB, 4'hF, 0, 0, 1, 0)); // rf[2]<=F
        tbl.push_back(mk(3, 1, 0, 0, 0, 4'h0, 2, 0, 4'hF, 4'hF, 0, 0, 1, 0)); // x<=F
        tbl.push_back(mk(2, 1, 1, 0, 0, 4'h0, 2, 0, 4'hE, 4'hF, 0, 1, 1, 0)); // F+F sets C
        tbl.push_back(mk(3, 1, 0, 0, 0, 4'h0, 2, 0, 4'hF, 4'hF, 0, 1, 1, 0)); // x<=F
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h0, 1, 1, 4'hF, 4'h0, 0, 1, 1, 0)); // rf[1]<=0
`ifdef DATAPATH_ADC_EN
        tbl.push_back(mk(7, 1, 1, 0, 0, 4'h0, 1, 0, 4'h0, 4'h0, 1, 1, 0, 0)); // F+0+C
        tbl.push_back(mk(7, 1, 1, 0, 0, 4'h0, 2, 0, 4'h0, 4'hF, 1, 1, 0, 0)); // 0+F+C
`else
        tbl.push_back(mk(7, 1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h0, 0, 1, 1, 0)); // F^0
        tbl.push_back(mk(7, 1, 1, 0, 0, 4'h0, 2, 0, 4'h0, 4'hF, 1, 1, 0, 0)); // F^F
`endif

        idle_inputs();
        reset = 1'b1;
        #2;
        check_cleared("por");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Read-during-write on the same address: old value this cycle, new value after.
        step(mk(0, 0, 0, 1, 1, 4'h1, 2, 2, 4'h0, 4'h1, 1, 1, 0, 0), 100);
        @(negedge clk);
        en_rf = 1'b1; rf_sel = 1'b1; imm = 4'h7; rd_addr = 2'd2; wr_addr = 2'd2;
        en_x = 1'b0; en_flag = 1'b0;
        #1;
        chk("rdw_old_y", 32'(y), 32'h1);
        @(posedge clk);
        #1;
        chk("rdw_new_y", 32'(y), 32'h7);

        // Random traffic, then reset asserted mid-cycle with enables still active.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            op_sel  = 3'($urandom_range(0, 7));
            en_x    = 1'($urandom_range(0, 1));
            en_flag = 1'($urandom_range(0, 1));
            en_rf   = 1'b1;
            rf_sel  = 1'($urandom_range(0, 1));
            imm     = WIDTH'($urandom_range(1, 15));
            wr_addr = AW'($urandom_range(0, NREGS - 1));
            rd_addr = AW'($urandom_range(0, NREGS - 1));
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_cleared("mid_rst");
        en_x = 1'b1; en_rf = 1'b1; en_flag = 1'b1; op_sel = 3'd1; rf_sel = 1'b1; imm = 4'hA;
        @(posedge clk);
        #1;
        check_cleared("rst_hold");
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_cleared("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
